// File: rtl/alu_resp_monitor_pkg.sv
// alu_resp_monitor_pkg: FSM state encodings, ALU flag bit positions and default widths
// shared by the ALU response monitor and its FIFO.
package alu_resp_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_FLAG_W = 4;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/alu_mon_fifo.sv
// alu_mon_fifo: show-ahead FIFO; head entry is presented combinationally, zero when empty.
// Writes while full and pops while empty are ignored; clr flushes synchronously.
module alu_mon_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr;
    logic          rd;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign wr      = wr_en && !full && !clr;
    assign rd      = rd_en && !empty && !clr;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two; count tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_resp_monitor.sv
// alu_resp_monitor: accepts ALU results, compares them to expectations, queues {result, flags,
// mismatch} and counts mismatches (saturating). ALU_MON_STOP_ON_ERR_EN enables halt-on-mismatch.
module alu_resp_monitor
    import alu_resp_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FLAG_W = DEF_FLAG_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [WIDTH-1:0]         res_data,
    input  logic [FLAG_W-1:0]        res_flags,
    input  logic [WIDTH-1:0]         exp_data,
    input  logic [FLAG_W-1:0]        exp_flags,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [FLAG_W-1:0]        rd_flags,
    output logic                     rd_mismatch,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         err_count,
    output logic                     halted
);

    localparam int EW = WIDTH + FLAG_W + 1;

    state_t          state;
    state_t          state_nxt;
    logic            mismatch;
    logic            accept;
    logic [EW-1:0]   head;

    assign mismatch = (res_data != exp_data) || (res_flags != exp_flags);
    assign accept   = res_valid && res_ready;
    assign {rd_data, rd_flags, rd_mismatch} = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Ready depends only on state and occupancy so upstream never sees a combinational loop.
    always_comb begin
        res_ready = !full && state != ST_HALT;
`ifdef ALU_MON_STOP_ON_ERR_EN
        halted    = state == ST_HALT;
        state_nxt = clr                             ? ST_IDLE :
                    (accept && mismatch)            ? ST_HALT :
                    (accept && state == ST_IDLE)    ? ST_RUN  : state;
`else
        halted    = 1'b0;
        state_nxt = clr                             ? ST_IDLE :
                    (accept && state == ST_IDLE)    ? ST_RUN  : state;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          err_count <= '0;
        else if (clr)                                     err_count <= '0;
        else if (accept && mismatch && err_count != '1)   err_count <= err_count + CNT_W'(1);
    end

    alu_mon_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (accept),
        .wr_data ({res_data, res_flags, mismatch}),
        .rd_en   (rd_en),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_alu_resp_monitor.sv
// tb_alu_resp_monitor: randomized scoreboard bench; a queue-based reference model tracks the
// expected FIFO contents, mismatch count and halt status, and a negedge monitor compares.
module tb_alu_resp_monitor;

    localparam int DEPTH = 8;
    localparam int EMAX  = 255;

    typedef struct {
        logic [7:0] d;
        logic [3:0] f;
        logic       m;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [7:0] res_data = '0;
    logic [3:0] res_flags = '0;
    logic [7:0] exp_data = '0;
    logic [3:0] exp_flags = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic [3:0] rd_flags;
    logic       rd_mismatch;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic [7:0] err_count;
    logic       halted;

    ent_t q[$];
    int   m_err  = 0;
    bit   m_halt = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    alu_resp_monitor #(.WIDTH(8), .FLAG_W(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .exp_data(exp_data), .exp_flags(exp_flags),
        .rd_en(rd_en), .rd_data(rd_data), .rd_flags(rd_flags), .rd_mismatch(rd_mismatch),
        .empty(empty), .full(full), .count(count), .err_count(err_count), .halted(halted)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return q.size() < DEPTH && !m_halt;
    endfunction

    function automatic void m_clear();
        q.delete();
        m_err  = 0;
        m_halt = 1'b0;
    endfunction

    // Monitor: every cycle, compare all outputs against the reference model's view.
    always @(negedge clk) begin
        chk("res_ready", int'(res_ready), int'(m_ready()));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("count", int'(count), q.size());
        chk("err_count", int'(err_count), m_err);
        chk("halted", int'(halted), int'(m_halt));
        if (q.size() > 0) begin
            chk("rd_data", int'(rd_data), int'(q[0].d));
            chk("rd_flags", int'(rd_flags), int'(q[0].f));
            chk("rd_mismatch", int'(rd_mismatch), int'(q[0].m));
        end else begin
            chk("rd_data_empty", int'(rd_data), 0);
            chk("rd_flags_empty", int'(rd_flags), 0);
            chk("rd_mismatch_empty", int'(rd_mismatch), 0);
        end
    end

    // Drive one cycle of inputs, then advance the model by the rules of the monitor.
    task automatic step(input logic v, input logic [7:0] d, input logic [7:0] ed,
                        input logic [3:0] f, input logic [3:0] ef, input logic rd, input logic c);
        bit acc;
        bit pop;
        bit mm;
        res_valid = v; res_data = d; exp_data = ed;
        res_flags = f; exp_flags = ef; rd_en = rd; clr = c;
        @(posedge clk);
        acc = v && m_ready();
        pop = rd && q.size() > 0;
        mm  = (d != ed) || (f != ef);
        if (c) begin
            m_clear();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back('{d, f, mm});
                if (mm) begin
                    if (m_err < EMAX) m_err++;
`ifdef ALU_MON_STOP_ON_ERR_EN
                    m_halt = 1'b1;
`endif
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic random_beat(input int mm_pct, input int rd_pct, input int clr_pct);
        logic [7:0] d;
        logic [3:0] f;
        logic [7:0] ed;
        logic [3:0] ef;
        d  = 8'($urandom);
        f  = 4'($urandom);
        ed = d;
        ef = f;
        if ($urandom_range(0, 99) < mm_pct) begin
            if ($urandom_range(0, 1) == 0) ed = d ^ 8'($urandom_range(1, 255));
            else ef = f ^ 4'($urandom_range(1, 15));
        end
        step($urandom_range(0, 3) != 0, d, ed, f, ef,
             $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < clr_pct);
    endtask

    initial begin
        m_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        // Fill with eight matching beats, hold one blocked beat against full, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 8'(i), 4'h5, 4'h5, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 8'hAA, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        // Single mismatch, then a matching beat (accepted only when not halted).
        step(1'b1, 8'h3C, 8'h3D, 4'h1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 8'h11, 8'h11, 4'h2, 4'h2, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        // Full FIFO with simultaneous pop and offered beat: pop only.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 16), 8'(i + 16), 4'h3, 4'h3, 1'b0, 1'b0);
        step(1'b1, 8'h77, 8'h77, 4'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 8'h78, 8'h78, 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        // Three entries with two mismatches, then clr racing a valid beat.
        step(1'b1, 8'h01, 8'h02, 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 8'h01, 8'h01, 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 8'h02, 4'h4, 4'h6, 1'b0, 1'b0);
        step(1'b1, 8'h03, 8'h05, 4'h0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 8'h09, 8'h09, 4'h0, 4'h0, 1'b1, 1'b1);
        idle(2);
        for (int i = 0; i < 1500; i++) random_beat(15, 55, 2);
`ifndef ALU_MON_STOP_ON_ERR_EN
        // Drive well past 255 mismatches to exercise saturation.
        step(1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 8'(i + 1), 4'h0, 4'h0, 1'b1, 1'b0);
`endif
        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 8'(i), 4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        m_clear();
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 200; i++) random_beat(10, 50, 3);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
